axi_lite_wr_slave: RTL and testbench

AXI_LITE_WR_SLAVE -- requirements
Module: axi_lite_wr_slave

---
 rtl/axi_lite_wr_slave.sv | 139 +++++++++++++
 tb/tb_axi_lite_wr_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_wr_slave.sv
// AXI4-Lite write-only slave that exposes a bank of NUM_REGS 32-bit registers.
// It handles one write at a time, with byte strobes and SLVERR for addresses outside the register bank.
module axi_lite_wr_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h4000_0000)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [ADDR_WIDTH-1:0]          axi_s_awaddr,
    input  logic                           axi_s_awvalid,
    output logic                           axi_s_awready,
    input  logic [DATA_WIDTH-1:0]          axi_s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_s_wstrb,
    input  logic                           axi_s_wvalid,
    output logic                           axi_s_wready,
    output logic [1:0]                     axi_s_bresp,
    output logic                           axi_s_bvalid,
    input  logic                           axi_s_bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [1:0]              r_bresp;
    logic [NUM_REGS-1:0]     r_wr_pulse;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_commit;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_ok;
    logic [IDX_W-1:0]        w_idx;
    logic [NUM_REGS-1:0]     w_sel;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        axi_s_awready = 1'b0;
        axi_s_wready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                axi_s_awready = 1'b1;
                axi_s_wready  = 1'b1;
                if (axi_s_awvalid && axi_s_wvalid) w_next = RESP;
                else if (axi_s_awvalid)            w_next = HAVE_AW;
                else if (axi_s_wvalid)             w_next = HAVE_W;
            end
            HAVE_AW: begin
                axi_s_wready = 1'b1;
                if (axi_s_wvalid) w_next = RESP;
            end
            HAVE_W: begin
                axi_s_awready = 1'b1;
                if (axi_s_awvalid) w_next = RESP;
            end
            RESP: begin
                if (axi_s_bready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_aw_hs  = axi_s_awvalid && axi_s_awready;
    assign w_w_hs   = axi_s_wvalid && axi_s_wready;
    assign w_commit = (w_next == RESP) && (r_state != RESP);

    // A channel that completes its handshake on the commit edge has not been captured yet, so use the live bus value.
    assign w_addr   = w_aw_hs ? axi_s_awaddr : r_awaddr;
    assign w_data   = w_w_hs  ? axi_s_wdata  : r_wdata;
    assign w_strb   = w_w_hs  ? axi_s_wstrb  : r_wstrb;

    assign w_offset = w_addr - BASE_ADDR;
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_ok     = (w_addr >= BASE_ADDR) && (w_offset[1:0] == 2'b00) &&
                      (w_offset[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(NUM_REGS));

    always_comb begin
        w_sel = '0;
        if (w_ok) w_sel[w_idx] = 1'b1;
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
        end else begin
            r_state    <= w_next;
            r_wr_pulse <= w_commit ? w_sel : '0;
            if (w_aw_hs)  r_awaddr <= axi_s_awaddr;
            if (w_w_hs) begin
                r_wdata <= axi_s_wdata;
                r_wstrb <= axi_s_wstrb;
            end
            if (w_commit) r_bresp <= w_ok ? 2'b00 : 2'b10;
        end
    end

    // NOTE: the register bank is built from discrete flops, so it is reset like any other state and is not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_sel[i] && w_strb[b]) r_regs[i][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign axi_s_bvalid = (r_state == RESP);
    assign axi_s_bresp  = r_bresp;
    assign wr_pulse     = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_wr_slave.sv
// Directed testbench for axi_lite_wr_slave. Expected register contents come from a small byte-strobe model
// that the bench keeps for itself.
module tb_axi_lite_wr_slave;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   axi_s_awaddr;
    logic          axi_s_awvalid;
    logic          axi_s_awready;
    logic [31:0]   axi_s_wdata;
    logic [3:0]    axi_s_wstrb;
    logic          axi_s_wvalid;
    logic          axi_s_wready;
    logic [1:0]    axi_s_bresp;
    logic          axi_s_bvalid;
    logic          axi_s_bready;
    logic [511:0]  reg_out;
    logic [15:0]   wr_pulse;

    logic [31:0]   exp_regs [16];
    int            n_checks = 0;
    int            n_errors = 0;

    axi_lite_wr_slave dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .axi_s_awaddr  (axi_s_awaddr),
        .axi_s_awvalid (axi_s_awvalid),
        .axi_s_awready (axi_s_awready),
        .axi_s_wdata   (axi_s_wdata),
        .axi_s_wstrb   (axi_s_wstrb),
        .axi_s_wvalid  (axi_s_wvalid),
        .axi_s_wready  (axi_s_wready),
        .axi_s_bresp   (axi_s_bresp),
        .axi_s_bvalid  (axi_s_bvalid),
        .axi_s_bready  (axi_s_bready),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] exp_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) exp_regs[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // Advance to just after the next rising edge; outputs are sampled and inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_s_awaddr  = a;
        axi_s_awvalid = 1'b1;
        axi_s_wdata   = d;
        axi_s_wstrb   = s;
        axi_s_wvalid  = 1'b1;
        step();
        axi_s_awvalid = 1'b0;
        axi_s_wvalid  = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        axi_s_awaddr  = '0;
        axi_s_awvalid = 1'b0;
        axi_s_wdata   = '0;
        axi_s_wstrb   = '0;
        axi_s_wvalid  = 1'b0;
        axi_s_bready  = 1'b1;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;

        #1;
        check("rst_awready", 512'(axi_s_awready), 512'(1));
        check("rst_wready",  512'(axi_s_wready),  512'(1));
        check("rst_bvalid",  512'(axi_s_bvalid),  512'(0));
        check("rst_bresp",   512'(axi_s_bresp),   512'(0));
        check("rst_pulse",   512'(wr_pulse),      512'(0));
        check("rst_regs",    reg_out,             512'(0));
        step();
        step();
        reset_n = 1'b1;
        step();

        // Both channels in one cycle: the response appears on the next cycle.
        send_both(32'h4000_0008, 32'hDEAD_BEEF, 4'hF);
        model_write(2, 32'hDEAD_BEEF, 4'hF);
        check("same_bvalid",  512'(axi_s_bvalid),  512'(1));
        check("same_bresp",   512'(axi_s_bresp),   512'(0));
        check("same_pulse",   512'(wr_pulse),      512'(16'h0004));
        check("same_reg2",    512'(reg_out[95:64]), 512'(32'hDEAD_BEEF));
        check("resp_awready", 512'(axi_s_awready), 512'(0));
        check("resp_wready",  512'(axi_s_wready),  512'(0));
        step();
        check("same_done_bvalid", 512'(axi_s_bvalid), 512'(0));
        check("same_done_pulse",  512'(wr_pulse),     512'(0));
        check("same_done_aw",     512'(axi_s_awready), 512'(1));

        // W arrives three cycles ahead of AW.
        axi_s_wdata  = 32'h1122_3344;
        axi_s_wstrb  = 4'b0101;
        axi_s_wvalid = 1'b1;
        step();
        axi_s_wvalid = 1'b0;
        check("havew_wready",  512'(axi_s_wready),  512'(0));
        check("havew_awready", 512'(axi_s_awready), 512'(1));
        check("havew_bvalid",  512'(axi_s_bvalid),  512'(0));
        step();
        step();
        check("havew_hold_wready", 512'(axi_s_wready), 512'(0));
        axi_s_awaddr  = 32'h4000_0000;
        axi_s_awvalid = 1'b1;
        step();
        axi_s_awvalid = 1'b0;
        model_write(0, 32'h1122_3344, 4'b0101);
        check("havew_bvalid_resp", 512'(axi_s_bvalid), 512'(1));
        check("havew_bresp",       512'(axi_s_bresp),  512'(0));
        check("havew_reg0",        512'(reg_out[31:0]), 512'(32'h0022_0044));
        check("havew_pulse",       512'(wr_pulse),     512'(16'h0001));
        check("havew_regs",        reg_out,            exp_flat());
        step();

        // AW ahead of W, partial strobe onto existing data.
        axi_s_awaddr  = 32'h4000_0008;
        axi_s_awvalid = 1'b1;
        step();
        axi_s_awvalid = 1'b0;
        check("haveaw_awready", 512'(axi_s_awready), 512'(0));
        check("haveaw_wready",  512'(axi_s_wready),  512'(1));
        axi_s_wdata  = 32'h0000_1234;
        axi_s_wstrb  = 4'b0011;
        axi_s_wvalid = 1'b1;
        step();
        axi_s_wvalid = 1'b0;
        model_write(2, 32'h0000_1234, 4'b0011);
        check("haveaw_bresp", 512'(axi_s_bresp),    512'(0));
        check("haveaw_reg2",  512'(reg_out[95:64]), 512'(32'hDEAD_1234));
        step();

        // Decode failures: index past the bank, misaligned, below the base.
        send_both(32'h4000_0040, 32'hFFFF_FFFF, 4'hF);
        check("oob_bresp", 512'(axi_s_bresp), 512'(2));
        check("oob_pulse", 512'(wr_pulse),    512'(0));
        check("oob_regs",  reg_out,           exp_flat());
        step();
        send_both(32'h4000_0006, 32'hFFFF_FFFF, 4'hF);
        check("misal_bresp", 512'(axi_s_bresp), 512'(2));
        check("misal_pulse", 512'(wr_pulse),    512'(0));
        step();
        send_both(32'h3FFF_FFFC, 32'hFFFF_FFFF, 4'hF);
        check("below_bresp", 512'(axi_s_bresp), 512'(2));
        check("below_regs",  reg_out,           exp_flat());
        step();

        // Last register with a single top-byte strobe.
        send_both(32'h4000_003C, 32'hA5A5_A5A5, 4'b1000);
        model_write(15, 32'hA5A5_A5A5, 4'b1000);
        check("last_bresp", 512'(axi_s_bresp),      512'(0));
        check("last_pulse", 512'(wr_pulse),         512'(16'h8000));
        check("last_reg15", 512'(reg_out[511:480]), 512'(32'hA500_0000));
        step();

        // Zero strobe: OKAY, pulse, data untouched.
        send_both(32'h4000_0008, 32'h0BAD_F00D, 4'b0000);
        check("nostrb_bresp", 512'(axi_s_bresp), 512'(0));
        check("nostrb_pulse", 512'(wr_pulse),    512'(16'h0004));
        check("nostrb_regs",  reg_out,           exp_flat());
        step();

        // Backpressure on B; new requests offered during RESP must be ignored.
        axi_s_bready = 1'b0;
        send_both(32'h4000_0014, 32'h5555_5555, 4'hF);
        model_write(5, 32'h5555_5555, 4'hF);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_bvalid", k),  512'(axi_s_bvalid),  512'(1));
            check($sformatf("bp%0d_bresp", k),   512'(axi_s_bresp),   512'(0));
            check($sformatf("bp%0d_awready", k), 512'(axi_s_awready), 512'(0));
            check($sformatf("bp%0d_wready", k),  512'(axi_s_wready),  512'(0));
            check($sformatf("bp%0d_pulse", k),   512'(wr_pulse),
                  (k == 0) ? 512'(16'h0020) : 512'(0));
            axi_s_awaddr  = 32'h4000_0018;
            axi_s_wdata   = 32'hFFFF_FFFF;
            axi_s_wstrb   = 4'hF;
            axi_s_awvalid = (k < 3);
            axi_s_wvalid  = (k < 3);
            if (k < 4) step();
        end
        axi_s_bready = 1'b1;
        step();
        check("bp_done_bvalid",  512'(axi_s_bvalid),  512'(0));
        check("bp_done_awready", 512'(axi_s_awready), 512'(1));
        check("bp_done_wready",  512'(axi_s_wready),  512'(1));
        check("bp_done_regs",    reg_out,             exp_flat());

        // Reset while holding an address: the transaction is abandoned.
        axi_s_awaddr  = 32'h4000_0010;
        axi_s_awvalid = 1'b1;
        step();
        axi_s_awvalid = 1'b0;
        check("mid_haveaw_awready", 512'(axi_s_awready), 512'(0));
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        check("mid_rst_regs",    reg_out,             512'(0));
        check("mid_rst_awready", 512'(axi_s_awready), 512'(1));
        check("mid_rst_wready",  512'(axi_s_wready),  512'(1));
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_bvalid",  512'(axi_s_bvalid),  512'(0));
        check("post_rst_awready", 512'(axi_s_awready), 512'(1));
        check("post_rst_wready",  512'(axi_s_wready),  512'(1));
        check("post_rst_pulse",   512'(wr_pulse),      512'(0));
        check("post_rst_regs",    reg_out,             exp_flat());
        axi_s_wdata  = 32'h7777_7777;
        axi_s_wstrb  = 4'hF;
        axi_s_wvalid = 1'b1;
        step();
        axi_s_wvalid = 1'b0;
        check("post_rst_w_bvalid", 512'(axi_s_bvalid), 512'(0));
        check("post_rst_w_wready", 512'(axi_s_wready), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
